// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types and constants for the instruction-fetch stage.
//   fetch_state_t : outstanding-request tracking for the imem handshake
//   BUBBLE_INSTR  : encoding loaded into IF/ID for a bubble (ANDEQ r0,r0,r0)
//   PC_STEP       : fetch PC increment per issued request
//   align_word()  : clears the byte-offset bits of an address
// -----------------------------------------------------------------------------
package fetch_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,  // nothing outstanding
        WAIT = 2'd1,  // one request outstanding, response will be kept
        DROP = 2'd2   // one request outstanding, response will be discarded
    } fetch_state_t;

    localparam logic [31:0] BUBBLE_INSTR = 32'h0000_0000;
    localparam logic [31:0] PC_STEP      = 32'd4;

    function automatic logic [31:0] align_word(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_hold_buf.sv
// -----------------------------------------------------------------------------
// fetch_hold_buf
// One-entry buffer that parks a fetched instruction while decode is stalled.
// Ports:
//   i_clk, i_rst_n    : clock, synchronous active-low reset
//   i_clear           : discard contents (redirect); wins over load
//   i_load            : capture {i_instr, i_pcplus8}, buffer becomes full
//   i_drain           : entry consumed by IF/ID, buffer becomes empty
//   o_full            : entry valid
//   o_instr/o_pcplus8 : stored instruction and its PC+8
// -----------------------------------------------------------------------------
module fetch_hold_buf
    import fetch_pkg::*;
(
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_clear,
    input  logic        i_load,
    input  logic        i_drain,
    input  logic [31:0] i_instr,
    input  logic [31:0] i_pcplus8,
    output logic        o_full,
    output logic [31:0] o_instr,
    output logic [31:0] o_pcplus8
);

    logic        r_full;
    logic [31:0] r_instr;
    logic [31:0] r_pcplus8;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            r_full    <= 1'b0;
            r_instr   <= BUBBLE_INSTR;
            r_pcplus8 <= 32'h0;
        end else if (i_load) begin
            r_full    <= 1'b1;
            r_instr   <= i_instr;
            r_pcplus8 <= i_pcplus8;
        end else if (i_drain) begin
            r_full <= 1'b0;
        end
    end

    assign o_full    = r_full;
    assign o_instr   = r_instr;
    assign o_pcplus8 = r_pcplus8;

endmodule

// File: rtl/fetch_stage.sv
// -----------------------------------------------------------------------------
// fetch_stage
// Instruction fetch plus IF/ID pipeline register. Owns the fetch PC, a
// single-outstanding variable-latency imem handshake, and a one-entry hold
// buffer that absorbs decode stalls. Redirects on execute-stage taken branches
// and writeback PC writes (writeback wins).
// Ports:
//   clk, reset           : clock, synchronous active-low reset
//   StallF, StallD       : hazard unit: block new fetches / hold IF/ID
//   FlushD               : hazard unit: bubble into IF/ID (beats StallD)
//   BranchTakenE/ALUResultE : execute-stage redirect and target
//   PCSrcW/ResultW       : writeback redirect and target
//   imem_req/imem_addr   : one-cycle request pulse and word address
//   imem_valid/imem_rdata: response strobe and instruction
//   InstrD/PCPlus8D/ValidD : IF/ID register contents
// -----------------------------------------------------------------------------
module fetch_stage
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        StallF,
    input  logic        StallD,
    input  logic        FlushD,
    input  logic        BranchTakenE,
    input  logic [31:0] ALUResultE,
    input  logic        PCSrcW,
    input  logic [31:0] ResultW,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] InstrD,
    output logic [31:0] PCPlus8D,
    output logic        ValidD
);

    fetch_state_t r_state;
    logic [31:0]  r_pc;
    logic [31:0]  r_instr_d;
    logic [31:0]  r_pcplus8_d;
    logic         r_valid_d;

    logic         w_redirect;
    logic [31:0]  w_target;
    logic         w_resp_keep;
    logic [31:0]  w_resp_pcplus8;
    logic         w_issue;
    logic         w_hold_full;
    logic         w_hold_load;
    logic         w_hold_drain;
    logic [31:0]  w_hold_instr;
    logic [31:0]  w_hold_pcplus8;

    always_comb begin
        w_redirect  = PCSrcW | BranchTakenE;
        w_target    = align_word(PCSrcW ? ResultW : ALUResultE);
        w_resp_keep = (r_state == WAIT) && imem_valid && !w_redirect;
        // r_pc already advanced past the outstanding request, so its PC+8 is r_pc+4.
        w_resp_pcplus8 = r_pc + PC_STEP;
        w_issue = reset && !StallF && !w_redirect && !w_hold_full &&
                  ((r_state == IDLE) || ((r_state == WAIT) && imem_valid && !StallD));
        w_hold_load  = w_resp_keep && !FlushD && StallD;
        w_hold_drain = w_hold_full && !FlushD && !StallD;
    end

    assign imem_req  = w_issue;
    assign imem_addr = r_pc;

    fetch_hold_buf u_hold_buf (
        .i_clk     (clk),
        .i_rst_n   (reset),
        .i_clear   (w_redirect),
        .i_load    (w_hold_load),
        .i_drain   (w_hold_drain),
        .i_instr   (imem_rdata),
        .i_pcplus8 (w_resp_pcplus8),
        .o_full    (w_hold_full),
        .o_instr   (w_hold_instr),
        .o_pcplus8 (w_hold_pcplus8)
    );

    // PC and request-tracking FSM
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= IDLE;
            r_pc    <= RESET_PC;
        end else if (w_redirect) begin
            r_pc <= w_target;
            // A response landing in the redirect cycle is simply discarded.
            r_state <= ((r_state != IDLE) && !imem_valid) ? DROP : IDLE;
        end else begin
            if (w_issue) begin
                r_pc <= r_pc + PC_STEP;
            end
            unique case (r_state)
                IDLE: if (w_issue) r_state <= WAIT;
                WAIT: if (imem_valid) r_state <= w_issue ? WAIT : IDLE;
                DROP: if (imem_valid) r_state <= IDLE;
                default: r_state <= IDLE;
            endcase
        end
    end

    // IF/ID register
    always_ff @(posedge clk) begin
        if (!reset || FlushD) begin
            r_instr_d   <= BUBBLE_INSTR;
            r_pcplus8_d <= 32'h0;
            r_valid_d   <= 1'b0;
        end else if (StallD) begin
            r_instr_d   <= r_instr_d;
            r_pcplus8_d <= r_pcplus8_d;
            r_valid_d   <= r_valid_d;
        end else if (w_hold_full) begin
            r_instr_d   <= w_hold_instr;
            r_pcplus8_d <= w_hold_pcplus8;
            r_valid_d   <= 1'b1;
        end else if (w_resp_keep) begin
            r_instr_d   <= imem_rdata;
            r_pcplus8_d <= w_resp_pcplus8;
            r_valid_d   <= 1'b1;
        end else begin
            r_instr_d   <= BUBBLE_INSTR;
            r_pcplus8_d <= 32'h0;
            r_valid_d   <= 1'b0;
        end
    end

    assign InstrD   = r_instr_d;
    assign PCPlus8D = r_pcplus8_d;
    assign ValidD   = r_valid_d;

endmodule

// File: tb/tb_fetch_stage.sv
// -----------------------------------------------------------------------------
// tb_fetch_stage
// Bench for fetch_stage. A latency-programmable memory model answers each
// request with addr|32'hE000_0000. Expected request addresses and expected
// IF/ID contents are queued as stimulus is driven and popped whenever the DUT
// issues a request or shows ValidD.
// -----------------------------------------------------------------------------
module tb_fetch_stage;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc8;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset, StallF, StallD, FlushD, BranchTakenE, PCSrcW;
    logic [31:0] ALUResultE, ResultW;
    logic        imem_req, imem_valid;
    logic [31:0] imem_addr, imem_rdata;
    logic [31:0] InstrD, PCPlus8D;
    logic        ValidD;

    logic [31:0] exp_addr_q[$];
    exp_t        exp_data_q[$];
    int          n_checks = 0;
    int          n_pass = 0;
    int          req_count = 0;
    int          mem_lat = 1;

    always #5 clk = ~clk;

    fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
        .clk          (clk),
        .reset        (reset),
        .StallF       (StallF),
        .StallD       (StallD),
        .FlushD       (FlushD),
        .BranchTakenE (BranchTakenE),
        .ALUResultE   (ALUResultE),
        .PCSrcW       (PCSrcW),
        .ResultW      (ResultW),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_valid   (imem_valid),
        .imem_rdata   (imem_rdata),
        .InstrD       (InstrD),
        .PCPlus8D     (PCPlus8D),
        .ValidD       (ValidD)
    );

    // Memory model: capture a request mid-cycle, answer mem_lat cycles later.
    initial begin
        logic        pend;
        logic [31:0] addr;
        int          cnt;
        pend = 1'b0;
        addr = 32'h0;
        cnt = 0;
        imem_valid = 1'b0;
        imem_rdata = 32'h0;
        forever begin
            @(negedge clk);
            if (imem_req === 1'b1) begin
                pend = 1'b1;
                addr = imem_addr;
                cnt = mem_lat;
            end
            @(posedge clk);
            #1;
            imem_valid = 1'b0;
            if (pend) begin
                cnt--;
                if (cnt == 0) begin
                    imem_valid = 1'b1;
                    imem_rdata = addr | 32'hE000_0000;
                    pend = 1'b0;
                end
            end
        end
    end

    // Sample mid-cycle and pop the scoreboard for any request / valid output.
    task automatic sample();
        logic [31:0] ea;
        exp_t        ed;
        @(negedge clk);
        if (imem_req === 1'b1) begin
            req_count++;
            n_checks++;
            if (exp_addr_q.size() == 0)
                $display("FAIL sb_req: unexpected request addr %h, none expected", imem_addr);
            else begin
                ea = exp_addr_q.pop_front();
                if (imem_addr !== ea)
                    $display("FAIL sb_req: imem_addr %h, expected %h", imem_addr, ea);
                else n_pass++;
            end
        end
        if (ValidD === 1'b1) begin
            n_checks++;
            if (exp_data_q.size() == 0)
                $display("FAIL sb_instr: unexpected InstrD %h, none expected", InstrD);
            else begin
                ed = exp_data_q.pop_front();
                if ({InstrD, PCPlus8D} !== {ed.instr, ed.pc8})
                    $display("FAIL sb_instr: InstrD/PCPlus8D %h/%h, expected %h/%h",
                             InstrD, PCPlus8D, ed.instr, ed.pc8);
                else n_pass++;
            end
        end
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic push_fetch(input logic [31:0] addr, input bit keep);
        exp_t e;
        exp_addr_q.push_back(addr);
        if (keep) begin
            e.instr = addr | 32'hE000_0000;
            e.pc8 = addr + 32'd8;
            exp_data_q.push_back(e);
        end
    endtask

    // Let fetch run until `target` requests have been seen, then stall it.
    task automatic wait_reqs(input int target);
        int budget = 50;
        while (req_count < target && budget > 0) begin
            sample();
            advance();
            budget--;
        end
        if (req_count < target) begin
            n_checks++;
            $display("FAIL wait_reqs: saw %0d requests, expected %0d", req_count, target);
        end
        StallF = 1'b1;
    endtask

    task automatic drain();
        StallF = 1'b1;
        repeat (8) begin
            sample();
            advance();
        end
        n_checks++;
        if (exp_addr_q.size() != 0)
            $display("FAIL drain_req: %0d requests outstanding, expected 0", exp_addr_q.size());
        else n_pass++;
        n_checks++;
        if (exp_data_q.size() != 0)
            $display("FAIL drain_instr: %0d instrs outstanding, expected 0", exp_data_q.size());
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b0; StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0;
        BranchTakenE = 1'b0; ALUResultE = 32'h0; PCSrcW = 1'b0; ResultW = 32'h0;
        advance();
        sample(); advance();
        sample();
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL rst_req: got %b, expected 0", imem_req);
        else n_pass++;
        n_checks++;
        if ({InstrD, PCPlus8D, ValidD} !== 65'h0)
            $display("FAIL rst_ifid: got %h/%h/%b, expected 0/0/0", InstrD, PCPlus8D, ValidD);
        else n_pass++;
        advance();
    endtask

    task automatic test_stream_l1();
        int target;
        mem_lat = 1;
        for (int i = 0; i < 4; i++) push_fetch(32'(i * 4), 1'b1);
        target = req_count + 4;
        reset = 1'b1; StallF = 1'b0;
        sample();
        n_checks++;
        if (ValidD !== 1'b0) $display("FAIL stream_c0_valid: got %b, expected 0", ValidD);
        else n_pass++;
        advance();
        sample();
        n_checks++;
        if (ValidD !== 1'b0) $display("FAIL stream_c1_valid: got %b, expected 0", ValidD);
        else n_pass++;
        advance();
        sample();
        n_checks++;
        if ({ValidD, InstrD, PCPlus8D} !== {1'b1, 32'hE000_0000, 32'h8})
            $display("FAIL stream_c2_first: got %b/%h/%h, expected 1/e0000000/00000008",
                     ValidD, InstrD, PCPlus8D);
        else n_pass++;
        advance();
        wait_reqs(target);
        drain();
    endtask

    task automatic test_hold_stall();
        mem_lat = 1;
        push_fetch(32'h10, 1'b1);
        push_fetch(32'h14, 1'b1);
        StallF = 1'b0; StallD = 1'b0;
        sample(); advance();
        StallD = 1'b1;
        for (int c = 1; c <= 4; c++) begin
            if (c == 4) StallD = 1'b0;
            sample();
            n_checks++;
            if (imem_req !== 1'b0) $display("FAIL hold_noreq_c%0d: got %b, expected 0", c, imem_req);
            else n_pass++;
            advance();
        end
        sample();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h14})
            $display("FAIL hold_resume_req: got %b/%h, expected 1/00000014", imem_req, imem_addr);
        else n_pass++;
        n_checks++;
        if ({ValidD, InstrD, PCPlus8D} !== {1'b1, 32'hE000_0010, 32'h18})
            $display("FAIL hold_release: got %b/%h/%h, expected 1/e0000010/00000018",
                     ValidD, InstrD, PCPlus8D);
        else n_pass++;
        advance();
        drain();
    endtask

    task automatic test_latency3();
        int target;
        mem_lat = 3;
        push_fetch(32'h18, 1'b1);
        push_fetch(32'h1C, 1'b1);
        target = req_count + 2;
        StallF = 1'b0;
        wait_reqs(target);
        drain();
    endtask

    task automatic test_branch_drop();
        mem_lat = 3;
        exp_addr_q.push_back(32'h20);  // its data must never reach IF/ID
        StallF = 1'b0;
        sample(); advance();
        StallF = 1'b1; BranchTakenE = 1'b1; ALUResultE = 32'h103;
        sample();
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL br_redirect_req: got %b, expected 0", imem_req);
        else n_pass++;
        advance();
        BranchTakenE = 1'b0; ALUResultE = 32'h0; StallF = 1'b0;
        push_fetch(32'h100, 1'b1);
        for (int c = 2; c <= 3; c++) begin
            sample();
            n_checks++;
            if (imem_req !== 1'b0) $display("FAIL br_drop_c%0d: got %b, expected 0", c, imem_req);
            else n_pass++;
            advance();
        end
        sample();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h100})
            $display("FAIL br_target_req: got %b/%h, expected 1/00000100", imem_req, imem_addr);
        else n_pass++;
        advance();
        drain();
    endtask

    task automatic test_pcsrc_priority();
        mem_lat = 1;
        PCSrcW = 1'b1; ResultW = 32'h200; BranchTakenE = 1'b1; ALUResultE = 32'h300;
        StallF = 1'b0;
        sample();
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL pcsrc_redirect_req: got %b, expected 0", imem_req);
        else n_pass++;
        advance();
        PCSrcW = 1'b0; ResultW = 32'h0; BranchTakenE = 1'b0; ALUResultE = 32'h0;
        push_fetch(32'h200, 1'b1);
        sample();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h200})
            $display("FAIL pcsrc_target: got %b/%h, expected 1/00000200", imem_req, imem_addr);
        else n_pass++;
        advance();
        drain();
    endtask

    task automatic test_flush_stall();
        mem_lat = 1;
        push_fetch(32'h204, 1'b1);
        push_fetch(32'h208, 1'b0);
        StallF = 1'b0;
        sample(); advance();
        sample(); advance();
        StallF = 1'b1; FlushD = 1'b1; StallD = 1'b1;
        sample();
        n_checks++;
        if ({ValidD, InstrD} !== {1'b1, 32'hE000_0204})
            $display("FAIL flush_pre: got %b/%h, expected 1/e0000204", ValidD, InstrD);
        else n_pass++;
        advance();
        FlushD = 1'b0; StallD = 1'b0;
        sample();
        n_checks++;
        if ({InstrD, PCPlus8D, ValidD} !== 65'h0)
            $display("FAIL flush_bubble: got %h/%h/%b, expected 0/0/0", InstrD, PCPlus8D, ValidD);
        else n_pass++;
        advance();
        sample();
        n_checks++;
        if (ValidD !== 1'b0) $display("FAIL flush_discard: got %b, expected 0", ValidD);
        else n_pass++;
        advance();
        drain();
    endtask

    task automatic test_reset_mid_wait();
        exp_t e;
        mem_lat = 1;
        push_fetch(32'h20C, 1'b1);
        push_fetch(32'h210, 1'b0);
        exp_addr_q.push_back(32'h0);
        e.instr = 32'hE000_0000;
        e.pc8 = 32'h8;
        exp_data_q.push_back(e);
        StallF = 1'b0;
        sample(); advance();
        mem_lat = 3;
        sample(); advance();
        reset = 1'b0;
        sample();
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL rstmid_req_c2: got %b, expected 0", imem_req);
        else n_pass++;
        advance();
        sample();
        n_checks++;
        if (imem_req !== 1'b0) $display("FAIL rstmid_req_c3: got %b, expected 0", imem_req);
        else n_pass++;
        n_checks++;
        if ({InstrD, PCPlus8D, ValidD} !== 65'h0)
            $display("FAIL rstmid_ifid: got %h/%h/%b, expected 0/0/0", InstrD, PCPlus8D, ValidD);
        else n_pass++;
        advance();
        reset = 1'b1;
        sample();
        n_checks++;
        if ({imem_req, imem_addr} !== {1'b1, 32'h0})
            $display("FAIL rstmid_restart: got %b/%h, expected 1/00000000", imem_req, imem_addr);
        else n_pass++;
        advance();
        drain();
    endtask

    initial begin
        test_reset();
        test_stream_l1();
        test_hold_stall();
        test_latency3();
        test_branch_drop();
        test_pcsrc_priority();
        test_flush_stall();
        test_reset_mid_wait();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
